// File: rtl/vie_mem_stage_pkg.sv
// Shared widths, field offsets and bus layouts for the memory stage and its
// neighbours (execute feeds rsbus, writeback consumes wbbus, issue reads mstatus).
package vie_mem_stage_pkg;

    localparam int RSBUS_W = 73;
    localparam int WBBUS_W = 72;
    localparam int MSTAT_W = 41;
    localparam int DEST_W  = 7;
    localparam int DATA_W  = 32;

    // Field positions inside the execute->mem bus.
    localparam int RS_VALID_BIT = 72;
    localparam int RS_LOAD_BIT  = 71;

    // Everything on rsbus below the valid bit, in bus order.
    typedef struct packed {
        logic                is_load;
        logic [DEST_W-1:0]   dest;
        logic [DATA_W-1:0]   fixres;
        logic [DATA_W-1:0]   pc;
    } ms_payload_t;

    // mem->wb bus layout.
    typedef struct packed {
        logic                valid;
        logic [DEST_W-1:0]   dest;
        logic [DATA_W-1:0]   result;
        logic [DATA_W-1:0]   pc;
    } wbbus_t;

    // Bypass/hazard status layout.
    typedef struct packed {
        logic                valid;
        logic                is_load;
        logic [DEST_W-1:0]   dest;
        logic [DATA_W-1:0]   result;
    } mstat_t;

    // Slice the payload fields out of the lower part of rsbus.
    function automatic ms_payload_t unpack_rsbus(input logic [RSBUS_W-2:0] bus);
        return ms_payload_t'(bus);
    endfunction

    // Pick the architectural result: loads take the returned data, others the ALU value.
    function automatic logic [DATA_W-1:0] select_result(
        input logic              is_load,
        input logic [DATA_W-1:0] load_data,
        input logic [DATA_W-1:0] fixres
    );
        return is_load ? load_data : fixres;
    endfunction

endpackage

// File: rtl/vie_mem_stage_ld_hold.sv
// One-entry holding register for load data that returns while writeback is
// stalled. A clear request always beats a capture request in the same cycle.
module vie_ld_hold
    import vie_mem_stage_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              capture,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dv
);

    logic [DATA_W-1:0] hold_d;
    logic [DATA_W-1:0] hold_q;
    logic              hold_v_d;
    logic              hold_v_q;

    // Next-state for the held word and its valid flag; clear has priority.
    always_comb begin
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        if (clear) begin
            hold_v_d = 1'b0;
        end else if (capture) begin
            hold_d   = din;
            hold_v_d = 1'b1;
        end else begin
            hold_d   = hold_q;
            hold_v_d = hold_v_q;
        end
    end

    // Hold register state with asynchronous reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_q   <= {DATA_W{1'b0}};
            hold_v_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

    assign dout = hold_q;
    assign dv   = hold_v_q;

endmodule

// File: rtl/vie_mem_stage.sv
// Memory stage: registers the execute result, merges the SRAM load data that
// arrives one cycle after the request, and drives writeback and bypass buses.
// Load data returning during a writeback stall is parked in vie_ld_hold so the
// outputs stay stable until writeback takes the entry.
module vie_mem_stage
    import vie_mem_stage_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic [RSBUS_W-1:0] rsbus_i,
    input  logic [DATA_W-1:0]  data_sram_rdata,
    input  logic               ws_allowin,
    output logic               ms_allowin,
    output logic [WBBUS_W-1:0] wbbus_o,
    output logic [MSTAT_W-1:0] mstatus_o
);

    logic        ms_valid_d;
    logic        ms_valid_q;
    logic        first_d;
    logic        first_q;
    ms_payload_t payload_d;
    ms_payload_t payload_q;

    logic              ms_allowin_s;
    logic              rs_valid_s;
    logic              accept_s;
    logic              hold_capture_s;
    logic              hold_clear_s;
    logic [DATA_W-1:0] hold_data_s;
    logic              hold_valid_s;
    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] result_s;
    wbbus_t            wb_s;
    mstat_t            mstat_s;

    // The stage never blocks on its own, so it can take a new entry whenever
    // it is empty or the current one is leaving to writeback.
    always_comb begin
        rs_valid_s   = rsbus_i[RS_VALID_BIT];
        ms_allowin_s = !ms_valid_q || ws_allowin;
        accept_s     = ms_allowin_s && rs_valid_s;
    end

    // Pipeline register next-state: valid follows rsbus whenever we can accept,
    // payload only loads on a real entry (bubbles leave it untouched), and
    // first marks the one cycle in which the SRAM data is live.
    always_comb begin
        ms_valid_d = ms_valid_q;
        payload_d  = payload_q;
        first_d    = 1'b0;
        if (ms_allowin_s) begin
            ms_valid_d = rs_valid_s;
        end else begin
            ms_valid_d = ms_valid_q;
        end
        if (accept_s) begin
            payload_d = unpack_rsbus(rsbus_i[RSBUS_W-2:0]);
            first_d   = 1'b1;
        end else begin
            payload_d = payload_q;
            first_d   = 1'b0;
        end
    end

    // Pipeline register, first-cycle flag and payload with asynchronous reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q <= 1'b0;
            first_q    <= 1'b0;
            payload_q  <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            first_q    <= first_d;
            payload_q  <= payload_d;
        end
    end

    // Park live load data only when it would otherwise be lost to a stall;
    // release the hold as soon as the entry leaves.
    always_comb begin
        hold_capture_s = ms_valid_q && payload_q.is_load && first_q && !ws_allowin;
        hold_clear_s   = ms_valid_q && ws_allowin;
    end

    vie_ld_hold u_ld_hold (
        .clock   (clock),
        .resetn  (resetn),
        .capture (hold_capture_s),
        .clear   (hold_clear_s),
        .din     (data_sram_rdata),
        .dout    (hold_data_s),
        .dv      (hold_valid_s)
    );

    // Result selection: parked data wins over the (possibly stale) SRAM bus.
    always_comb begin
        load_data_s = hold_valid_s ? hold_data_s : data_sram_rdata;
        result_s    = select_result(payload_q.is_load, load_data_s, payload_q.fixres);
    end

    // Output bus packing; dest passes through untouched, writeback filters dest 0.
    always_comb begin
        wb_s.valid       = ms_valid_q;
        wb_s.dest        = payload_q.dest;
        wb_s.result      = result_s;
        wb_s.pc          = payload_q.pc;
        mstat_s.valid    = ms_valid_q;
        mstat_s.is_load  = payload_q.is_load;
        mstat_s.dest     = payload_q.dest;
        mstat_s.result   = result_s;
    end

    assign ms_allowin = ms_allowin_s;
    assign wbbus_o    = wb_s;
    assign mstatus_o  = mstat_s;

endmodule

// File: tb/tb_vie_mem_stage.sv
// Directed bench for vie_mem_stage. A small entry-level model tracks what the
// stage holds and what its load value must be; a negedge process compares the
// DUT against it every cycle, and literal checks pin the directed scenarios.
module tb_vie_mem_stage;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [72:0] rsbus_i = '0;
    logic [31:0] rdata = '0;
    logic        ws_allowin = 1'b0;
    logic        ms_allowin;
    logic [71:0] wbbus_o;
    logic [40:0] mstatus_o;

    int n_chk  = 0;
    int n_fail = 0;

    vie_mem_stage dut (
        .clock           (clock),
        .resetn          (resetn),
        .rsbus_i         (rsbus_i),
        .data_sram_rdata (rdata),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .wbbus_o         (wbbus_o),
        .mstatus_o       (mstatus_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: the entry in the stage and the load value it must report. The load
    // value is whatever rdata showed in the first cycle the entry sat here.
    logic        m_valid = 1'b0;
    logic        m_ld    = 1'b0;
    logic [6:0]  m_dest  = '0;
    logic [31:0] m_fix   = '0;
    logic [31:0] m_pc    = '0;
    logic        m_known = 1'b0;
    logic [31:0] m_ldval = '0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_known <= 1'b0;
        end else begin
            if (m_valid && !m_known) begin
                m_ldval <= rdata;
                m_known <= 1'b1;
            end
            if (!m_valid || ws_allowin) begin
                m_valid <= rsbus_i[72];
                if (rsbus_i[72]) begin
                    m_ld    <= rsbus_i[71];
                    m_dest  <= rsbus_i[70:64];
                    m_fix   <= rsbus_i[63:32];
                    m_pc    <= rsbus_i[31:0];
                    m_known <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        logic [31:0] res;
        check("allowin", {71'd0, ms_allowin}, {71'd0, (!m_valid || ws_allowin)});
        if (m_valid) begin
            res = m_ld ? (m_known ? m_ldval : rdata) : m_fix;
            check("model_wb", wbbus_o, {1'b1, m_dest, res, m_pc});
            check("model_mst", {31'd0, mstatus_o}, {31'd0, 1'b1, m_ld, m_dest, res});
        end else begin
            check("model_wb_v", {71'd0, wbbus_o[71]}, 72'd0);
            check("model_mst_v", {71'd0, mstatus_o[40]}, 72'd0);
        end
    end

    task automatic drive(input logic v, input logic ld, input logic [6:0] d,
                         input logic [31:0] f, input logic [31:0] p,
                         input logic ws, input logic [31:0] rd);
        rsbus_i    = {v, ld, d, f, p};
        ws_allowin = ws;
        rdata      = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1 resetn = 1'b0;
        #20;
        check("rst_wb", wbbus_o, 72'd0);
        check("rst_mst", {31'd0, mstatus_o}, 72'd0);
        check("rst_allow", {71'd0, ms_allowin}, 72'd1);
        @(negedge clock);
        #1 resetn = 1'b1;
        tick();

        // 1: ALU pass-through
        drive(1'b1, 1'b0, 7'd5, 32'h0000_1234, 32'hbfc0_0000, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("t1_wb", wbbus_o, {1'b1, 7'd5, 32'h0000_1234, 32'hbfc0_0000});
        check("t1_mst", {31'd0, mstatus_o}, {31'd0, 1'b1, 1'b0, 7'd5, 32'h0000_1234});
        tick();

        // 2: load, no stall
        drive(1'b1, 1'b1, 7'd8, 32'h0000_0055, 32'h0000_0100, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b1, 32'hdead_beef);
        check("t2_wb", wbbus_o, {1'b1, 7'd8, 32'hdead_beef, 32'h0000_0100});
        check("t2_mst", {31'd0, mstatus_o}, {31'd0, 1'b1, 1'b1, 7'd8, 32'hdead_beef});
        tick();

        // 3: load under a 3-cycle stall, rdata goes to 0 after the first cycle
        drive(1'b1, 1'b1, 7'd9, 32'h0, 32'h0000_0200, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b0, 32'hdead_beef);
        check("t3_s1", wbbus_o, {1'b1, 7'd9, 32'hdead_beef, 32'h0000_0200});
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("t3_s2", wbbus_o, {1'b1, 7'd9, 32'hdead_beef, 32'h0000_0200});
        check("t3_allow", {71'd0, ms_allowin}, 72'd0);
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("t3_s3", wbbus_o, {1'b1, 7'd9, 32'hdead_beef, 32'h0000_0200});
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("t3_go", wbbus_o, {1'b1, 7'd9, 32'hdead_beef, 32'h0000_0200});
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("t3_gone", {71'd0, wbbus_o[71]}, 72'd0);

        // 4: back-to-back load then ALU
        drive(1'b1, 1'b1, 7'd10, 32'h0, 32'h0000_0300, 1'b1, 32'h0);
        tick();
        drive(1'b1, 1'b0, 7'd11, 32'hbbbb_0002, 32'h0000_0304, 1'b1, 32'haaaa_0001);
        check("t4_a", wbbus_o, {1'b1, 7'd10, 32'haaaa_0001, 32'h0000_0300});
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b1, 32'h0000_0077);
        check("t4_b", wbbus_o, {1'b1, 7'd11, 32'hbbbb_0002, 32'h0000_0304});
        tick();

        // 5: held load leaves in the same cycle a new load enters
        drive(1'b1, 1'b1, 7'd12, 32'h0, 32'h0000_0400, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b0, 32'h1111_1111);
        tick();
        drive(1'b1, 1'b1, 7'd13, 32'h0, 32'h0000_0404, 1'b0, 32'h0);
        check("t5_stall", wbbus_o, {1'b1, 7'd12, 32'h1111_1111, 32'h0000_0400});
        tick();
        drive(1'b1, 1'b1, 7'd13, 32'h0, 32'h0000_0404, 1'b1, 32'h0);
        check("t5_leave", wbbus_o, {1'b1, 7'd12, 32'h1111_1111, 32'h0000_0400});
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b1, 32'h2222_2222);
        check("t5_new", wbbus_o, {1'b1, 7'd13, 32'h2222_2222, 32'h0000_0404});
        tick();

        // 6: async reset in the middle of a stall
        drive(1'b1, 1'b0, 7'd14, 32'h0000_0e0e, 32'h0000_0500, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        resetn = 1'b0;
        #1;
        check("t6_wb_v", {71'd0, wbbus_o[71]}, 72'd0);
        check("t6_mst_v", {71'd0, mstatus_o[40]}, 72'd0);
        check("t6_allow", {71'd0, ms_allowin}, 72'd1);
        @(negedge clock);
        #1 resetn = 1'b1;
        drive(1'b1, 1'b0, 7'd3, 32'h0000_0033, 32'h0000_0600, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("t6_flow", wbbus_o, {1'b1, 7'd3, 32'h0000_0033, 32'h0000_0600});
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
